// File: rtl/alu_shift_sequencer_pkg.sv
// Shared constants for the multi-cycle shift sequencer: ALU op-select codes and FSM state encoding.
package alu_shift_sequencer_pkg;

    localparam int unsigned ALU_OP_SEL_WIDTH = 4;

    localparam logic [ALU_OP_SEL_WIDTH-1:0] ALUCTL_ADD = 4'h0;
    localparam logic [ALU_OP_SEL_WIDTH-1:0] ALUCTL_SLL = 4'h1;
    localparam logic [ALU_OP_SEL_WIDTH-1:0] ALUCTL_SRL = 4'h5;
    localparam logic [ALU_OP_SEL_WIDTH-1:0] ALUCTL_SRA = 4'hD;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/alu_shift_sequencer_shift_step.sv
// One combinational shift step of up to STEP bits; vacated bits on a right shift take the fill bit.
module alu_shift_sequencer_shift_step #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STEP       = 4,
    parameter int unsigned N_W        = $clog2(STEP) + 1
) (
    input  logic [DATA_WIDTH-1:0] acc_i,
    input  logic [N_W-1:0]        n_i,
    input  logic                  dir_right_i,
    input  logic                  fill_i,
    output logic [DATA_WIDTH-1:0] acc_o
);

    logic [DATA_WIDTH-1:0] fill_mask;

    always_comb begin
        fill_mask = ~({DATA_WIDTH{1'b1}} >> n_i);
        if (dir_right_i) begin
            acc_o = (acc_i >> n_i) | (fill_i ? fill_mask : '0);
        end else begin
            acc_o = acc_i << n_i;
        end
    end

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA sequencer: shifts STEP bits per cycle, stalls via busy_o, valid/ready result.
module alu_shift_sequencer
    import alu_shift_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SHAMT_WIDTH  = 5,
    parameter int unsigned STEP         = 4,
    parameter int unsigned OP_SEL_WIDTH = ALU_OP_SEL_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [OP_SEL_WIDTH-1:0] op_sel_i,
    input  logic [DATA_WIDTH-1:0]   operand_i,
    input  logic [SHAMT_WIDTH-1:0]  shamt_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [DATA_WIDTH-1:0]   result_o,
    output logic                    err_o,
    output logic                    busy_o
);

    localparam int unsigned N_W = $clog2(STEP) + 1;

    logic [1:0]             state_q, state_d;
    logic [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [SHAMT_WIDTH-1:0] rem_q, rem_d;
    logic                   dir_q, dir_d;
    logic                   fill_q, fill_d;
    logic                   err_q, err_d;
    logic                   res_valid_q, res_valid_d;

    logic [N_W-1:0]         step_n;
    logic [SHAMT_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0]  acc_shifted;
    logic                   is_sll, is_srl, is_sra, op_legal;

    assign is_sll   = (op_sel_i == OP_SEL_WIDTH'(ALUCTL_SLL));
    assign is_srl   = (op_sel_i == OP_SEL_WIDTH'(ALUCTL_SRL));
    assign is_sra   = (op_sel_i == OP_SEL_WIDTH'(ALUCTL_SRA));
    assign op_legal = is_sll | is_srl | is_sra;

    assign req_ready_o = (state_q == ST_IDLE) & ~flush_i;
    assign busy_o      = (state_q != ST_IDLE);
    assign res_valid_o = res_valid_q;
    assign result_o    = acc_q;
    assign err_o       = err_q;

    // Comparison done one bit wider so STEP == DATA_WIDTH does not truncate to zero.
    always_comb begin
        if ({1'b0, rem_q} >= (SHAMT_WIDTH + 1)'(STEP)) begin
            step_n = N_W'(STEP);
        end else begin
            step_n = N_W'(rem_q);
        end
        rem_next = rem_q - SHAMT_WIDTH'(step_n);
    end

    alu_shift_sequencer_shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP       (STEP),
        .N_W        (N_W)
    ) u_shift_step (
        .acc_i       (acc_q),
        .n_i         (step_n),
        .dir_right_i (dir_q),
        .fill_i      (fill_q),
        .acc_o       (acc_shifted)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        dir_d       = dir_q;
        fill_d      = fill_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    acc_d  = operand_i;
                    rem_d  = shamt_i;
                    dir_d  = ~is_sll;
                    fill_d = is_sra & operand_i[DATA_WIDTH-1];
                    err_d  = 1'b0;
                    if (!op_legal) begin
                        acc_d       = '0;
                        rem_d       = '0;
                        err_d       = 1'b1;
                        state_d     = ST_DONE;
                        res_valid_d = 1'b1;
                    end else if (shamt_i == '0) begin
                        state_d     = ST_DONE;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = acc_shifted;
                rem_d = rem_next;
                if (rem_next == '0) begin
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
            end
        endcase

        // Flush overrides everything; a same-cycle DONE handshake still completes since valid was visible.
        if (flush_i) begin
            state_d     = ST_IDLE;
            rem_d       = '0;
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            dir_q       <= 1'b0;
            fill_q      <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            dir_q       <= dir_d;
            fill_q      <= fill_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer with hand-computed results and cycle counts.
module tb_alu_shift_sequencer;
    import alu_shift_sequencer_pkg::*;

    logic                        clk_i;
    logic                        rst_i;
    logic                        flush_i;
    logic                        req_valid_i;
    logic                        req_ready_o;
    logic [ALU_OP_SEL_WIDTH-1:0] op_sel_i;
    logic [31:0]                 operand_i;
    logic [4:0]                  shamt_i;
    logic                        res_valid_o;
    logic                        res_ready_i;
    logic [31:0]                 result_o;
    logic                        err_o;
    logic                        busy_o;

    int checks;
    int failures;

    alu_shift_sequencer #(
        .DATA_WIDTH   (32),
        .SHAMT_WIDTH  (5),
        .STEP         (4),
        .OP_SEL_WIDTH (ALU_OP_SEL_WIDTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .op_sel_i    (op_sel_i),
        .operand_i   (operand_i),
        .shamt_i     (shamt_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .result_o    (result_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request and let it be accepted on the next edge; returns #1 after the accept edge.
    task automatic issue(input logic [ALU_OP_SEL_WIDTH-1:0] op, input logic [31:0] val,
                         input logic [4:0] sh);
        op_sel_i    = op;
        operand_i   = val;
        shamt_i     = sh;
        req_valid_i = 1'b1;
        #1;
        check("req_ready_before_accept", {31'd0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
    endtask

    // Edges after the accept edge until res_valid_o is seen, bounded at 40.
    task automatic wait_result(output int edges);
        edges = 0;
        while (!res_valid_o && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    int lat;
    int busy_cycles;

    initial begin
        checks      = 0;
        failures    = 0;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        res_ready_i = 1'b1;
        op_sel_i    = ALUCTL_ADD;
        operand_i   = '0;
        shamt_i     = '0;
        repeat (2) tick();

        check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        rst_i = 1'b0;
        tick();

        // SLL 1 << 5: two 4/1-bit steps
        issue(ALUCTL_SLL, 32'h0000_0001, 5'd5);
        check("t1_busy", {31'd0, busy_o}, 32'd1);
        wait_result(lat);
        check("t1_latency", lat, 32'd2);
        check("t1_result", result_o, 32'h0000_0020);
        check("t1_err", {31'd0, err_o}, 32'd0);
        tick();
        check("t1_valid_dropped", {31'd0, res_valid_o}, 32'd0);
        check("t1_idle", {31'd0, busy_o}, 32'd0);

        // SRA / SRL by 31: eight steps
        issue(ALUCTL_SRA, 32'h8000_0000, 5'd31);
        wait_result(lat);
        check("t2_sra_latency", lat, 32'd8);
        check("t2_sra_result", result_o, 32'hFFFF_FFFF);
        tick();
        issue(ALUCTL_SRL, 32'h8000_0000, 5'd31);
        wait_result(lat);
        check("t2_srl_latency", lat, 32'd8);
        check("t2_srl_result", result_o, 32'h0000_0001);
        tick();

        // SRL by 0: result straight after the accept edge, busy for exactly one cycle
        issue(ALUCTL_SRL, 32'hDEAD_BEEF, 5'd0);
        busy_cycles = 0;
        check("t3_valid_now", {31'd0, res_valid_o}, 32'd1);
        check("t3_result", result_o, 32'hDEAD_BEEF);
        while (busy_o && busy_cycles < 40) begin
            busy_cycles++;
            tick();
        end
        check("t3_busy_cycles", busy_cycles, 32'd1);

        // SLL F by 4 with consumer stalled for 5 cycles; a new request waits for the handshake
        res_ready_i = 1'b0;
        issue(ALUCTL_SLL, 32'h0000_000F, 5'd4);
        wait_result(lat);
        check("t4_latency", lat, 32'd1);
        op_sel_i    = ALUCTL_SLL;
        operand_i   = 32'h0000_0001;
        shamt_i     = 5'd1;
        req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_result", result_o, 32'h0000_00F0);
            check("t4_hold_valid", {31'd0, res_valid_o}, 32'd1);
            check("t4_hold_ready", {31'd0, req_ready_o}, 32'd0);
            tick();
        end
        res_ready_i = 1'b1;
        tick();
        check("t4_after_hs_valid", {31'd0, res_valid_o}, 32'd0);
        check("t4_after_hs_idle", {31'd0, busy_o}, 32'd0);
        tick();
        req_valid_i = 1'b0;
        check("t4_next_accepted", {31'd0, busy_o}, 32'd1);
        wait_result(lat);
        check("t4_next_latency", lat, 32'd1);
        check("t4_next_result", result_o, 32'h0000_0002);
        tick();

        // SRL by 16 flushed in its second cycle, together with a competing request
        issue(ALUCTL_SRL, 32'h8000_0000, 5'd16);
        tick();
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        #1;
        check("t5_ready_under_flush", {31'd0, req_ready_o}, 32'd0);
        tick();
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        check("t5_idle_after_flush", {31'd0, busy_o}, 32'd0);
        check("t5_no_valid", {31'd0, res_valid_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t5_stays_idle", {30'd0, busy_o, res_valid_o}, 32'd0);
            tick();
        end

        // Illegal op returns an error result; then reset lands in the middle of a shift
        issue(ALUCTL_ADD, 32'h1234_5678, 5'd3);
        check("t6_err_valid", {31'd0, res_valid_o}, 32'd1);
        check("t6_err", {31'd0, err_o}, 32'd1);
        check("t6_err_result", result_o, 32'd0);
        tick();
        issue(ALUCTL_SRA, 32'h8000_0000, 5'd31);
        repeat (3) tick();
        check("t6_mid_shift_busy", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        check("t6_rst_valid", {31'd0, res_valid_o}, 32'd0);
        check("t6_rst_result", result_o, 32'd0);
        check("t6_rst_err", {31'd0, err_o}, 32'd0);
        check("t6_rst_ready", {31'd0, req_ready_o}, 32'd1);
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t6_no_result_after_rst", {31'd0, res_valid_o}, 32'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
